// File: rtl/maxpool_2x2.sv
// Streaming 2x2 stride-2 max-pool for one signed feature-map channel in raster order.
// Keeps a half-width line buffer of horizontal pair maxima from each even row.
module maxpool_2x2 #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_W      = 4,
  parameter int unsigned IMG_H      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] data,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] result,
  output logic                         frame_done
);

  localparam int unsigned COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int unsigned LB_N  = IMG_W / 2;
  localparam int unsigned LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;

  logic        [COL_W-1:0]      r_col;
  logic        [ROW_W-1:0]      r_row;
  logic signed [DATA_WIDTH-1:0] r_pair;
  logic signed [DATA_WIDTH-1:0] r_lb [LB_N];
  logic signed [DATA_WIDTH-1:0] r_result;
  logic                         r_out_valid;
  logic                         r_frame_done;

  logic                         w_col_last;
  logic                         w_row_last;
  logic        [LB_AW-1:0]      w_lb_idx;
  logic signed [DATA_WIDTH-1:0] w_pmax;
  logic signed [DATA_WIDTH-1:0] w_lb_rd;
  logic signed [DATA_WIDTH-1:0] w_wmax;

  assign w_col_last = (r_col == COL_W'(IMG_W - 1));
  assign w_row_last = (r_row == ROW_W'(IMG_H - 1));
  assign w_lb_idx   = LB_AW'(r_col >> 1);
  assign w_pmax     = (data > r_pair) ? data : r_pair;
  assign w_lb_rd    = r_lb[w_lb_idx];
  assign w_wmax     = (w_lb_rd > w_pmax) ? w_lb_rd : w_pmax;

  // Raster counters, pair register and registered pooled output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_col        <= '0;
      r_row        <= '0;
      r_pair       <= '0;
      r_result     <= '0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      if (in_valid) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
        if (!r_col[0]) begin
          r_pair <= data;
        end else if (r_row[0]) begin
          r_result     <= w_wmax;
          r_out_valid  <= 1'b1;
          r_frame_done <= w_col_last && w_row_last;
        end
      end
    end
  end

  // Line buffer needs no reset: every entry is rewritten on an even row before its odd-row read.
  always_ff @(posedge clk) begin
    if (!reset && in_valid && r_col[0] && !r_row[0]) begin
      r_lb[w_lb_idx] <= w_pmax;
    end
  end

  assign out_valid  = r_out_valid;
  assign result     = r_result;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_maxpool_2x2.sv
// Self-checking bench for maxpool_2x2: image-level reference model plus directed literal checks.
module tb_maxpool_2x2;

  localparam int unsigned DW = 8;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] data = '0;
  logic                 out_valid;
  logic signed [DW-1:0] result;
  logic                 frame_done;

  maxpool_2x2 #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .data(data),
    .out_valid(out_valid), .result(result), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: stores the whole image and pools each completed 2x2 window.
  int img [H][W];
  int pix_idx = 0;
  int exp_result = 0;
  bit exp_valid = 1'b0;
  bit exp_done = 1'b0;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  always @(posedge clk) begin
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    if (reset) begin
      pix_idx    = 0;
      exp_result = 0;
    end else if (in_valid) begin
      int r, c;
      r = pix_idx / W;
      c = pix_idx % W;
      img[r][c] = int'(data);
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        exp_result = max2(max2(img[r-1][c-1], img[r-1][c]), max2(img[r][c-1], img[r][c]));
        exp_valid  = 1'b1;
        exp_done   = (pix_idx == W * H - 1);
      end
      pix_idx = (pix_idx + 1) % (W * H);
    end
  end

  // Per-cycle compare against the model, plus capture of emitted results for literal checks.
  int got_q [$];
  bit gotd_q [$];

  always @(posedge clk) begin
    #1;
    chk("out_valid", int'(out_valid), int'(exp_valid));
    chk("frame_done", int'(frame_done), int'(exp_done));
    chk("result", int'(result), exp_result);
    if (out_valid) begin
      got_q.push_back(int'(result));
      gotd_q.push_back(frame_done);
    end
  end

  int exp_q [$];
  bit expd_q [$];

  task automatic check_seq(input string name);
    chk({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_val%0d", name, i), got_q[i], exp_q[i]);
      chk($sformatf("%s_done%0d", name, i), int'(gotd_q[i]), int'(expd_q[i]));
    end
    got_q.delete();
    gotd_q.delete();
    exp_q.delete();
    expd_q.delete();
  endtask

  task automatic send(input int v);
    in_valid = 1'b1;
    data     = DW'(v);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset values, during reset and on the first cycle after release.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_result", int'(result), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", int'(out_valid), 0);
    chk("post_rst_frame_done", int'(frame_done), 0);
    chk("post_rst_result", int'(result), 0);
    got_q.delete();
    gotd_q.delete();

    // Ramp 0..15 back-to-back.
    for (int k = 0; k < 16; k++) send(k);
    idle(3);
    exp_q = '{5, 7, 13, 15};
    expd_q = '{1'b0, 1'b0, 1'b0, 1'b1};
    check_seq("ramp");

    // Signed window: must pick -1, not a large-magnitude negative.
    for (int k = 0; k < 16; k++) begin
      case (k)
        0: send(-128);
        1: send(-1);
        4: send(-5);
        5: send(-3);
        default: send(-100);
      endcase
    end
    idle(3);
    exp_q = '{-1, -100, -100, -100};
    expd_q = '{1'b0, 1'b0, 1'b0, 1'b1};
    check_seq("signed");

    // Bubbles after every pixel.
    for (int k = 0; k < 16; k++) begin
      send(k);
      idle(1);
    end
    idle(2);
    exp_q = '{5, 7, 13, 15};
    expd_q = '{1'b0, 1'b0, 1'b0, 1'b1};
    check_seq("bubble");

    // Reset mid-frame, with a pixel presented during reset that must be dropped.
    for (int k = 0; k < 10; k++) send(k);
    idle(2);
    got_q.delete();
    gotd_q.delete();
    reset    = 1'b1;
    in_valid = 1'b1;
    data     = DW'(99);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_result", int'(result), 0);
    for (int k = 0; k < 16; k++) send(50 + k);
    idle(3);
    exp_q = '{55, 57, 63, 65};
    expd_q = '{1'b0, 1'b0, 1'b0, 1'b1};
    check_seq("midrst");

    // Two frames with no gap.
    for (int k = 0; k < 32; k++) send(k);
    idle(3);
    exp_q = '{5, 7, 13, 15, 21, 23, 29, 31};
    expd_q = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    check_seq("b2b");

    // Output holds across idle cycles.
    chk("hold_result", int'(result), 31);
    chk("hold_out_valid", int'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
